// File: rtl/sar_search_ctrl_pkg.sv
// Shared types and helpers for the successive-approximation search controller.
package sar_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    SEARCH = 1'b1
  } sar_state_t;

  // Exactly one of the comparator's three flags may be set on a valid probe.
  function automatic logic is_onehot3(input logic gt, input logic lt, input logic eq);
    return ({gt, lt, eq} == 3'b100) || ({gt, lt, eq} == 3'b010) || ({gt, lt, eq} == 3'b001);
  endfunction

endpackage

// File: rtl/sar_search_ctrl_if.sv
// Controller <-> comparator/datapath bundle; master is the search controller.
interface sar_search_ctrl_if
  import sar_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
);
  // No valid/ready pair here: start is a level sampled only in IDLE, and done is a
  // single-cycle pulse with result/err/probes held stable until the next accepted start.
  logic             start;
  logic             cmp_gt;
  logic             cmp_lt;
  logic             cmp_eq;
  logic [WIDTH-1:0] trial;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             err;
  logic [CNT_W-1:0] probes;
  sar_state_t       dbgState;

  modport master (
    input  start, cmp_gt, cmp_lt, cmp_eq,
    output trial, busy, done, result, err, probes, dbgState
  );

  modport slave (
    output start, cmp_gt, cmp_lt, cmp_eq,
    input  trial, busy, done, result, err, probes, dbgState
  );
endinterface

// File: rtl/sar_search_ctrl.sv
// Binary search over the comparator's B input: one probe per clock, early exit on equality.
module sar_search_ctrl
  import sar_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  sar_search_ctrl_if.master  bus
);

  sar_state_t       stateQ, stateD;
  logic [WIDTH-1:0] trialQ, trialD;
  logic [WIDTH-1:0] accQ, accD;
  logic [CNT_W-1:0] bitIdxQ, bitIdxD;
  logic [WIDTH-1:0] resultQ, resultD;
  logic             errQ, errD;
  logic [CNT_W-1:0] probesQ, probesD;
  logic             doneQ, doneD;
  logic [WIDTH-1:0] accNext;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateQ  <= IDLE;
      trialQ  <= '0;
      accQ    <= '0;
      bitIdxQ <= CNT_W'(WIDTH - 1);
      resultQ <= '0;
      errQ    <= 1'b0;
      probesQ <= '0;
      doneQ   <= 1'b0;
    end else begin
      stateQ  <= stateD;
      trialQ  <= trialD;
      accQ    <= accD;
      bitIdxQ <= bitIdxD;
      resultQ <= resultD;
      errQ    <= errD;
      probesQ <= probesD;
      doneQ   <= doneD;
    end
  end

  always_comb begin
    stateD  = stateQ;
    trialD  = trialQ;
    accD    = accQ;
    bitIdxD = bitIdxQ;
    resultD = resultQ;
    errD    = errQ;
    probesD = probesQ;
    doneD   = 1'b0;
    // A "target greater" answer keeps the probed bit; "target less" drops it.
    accNext = bus.cmp_gt ? trialQ : accQ;

    unique case (stateQ)
      IDLE: begin
        trialD = '0;
        if (bus.start) begin
          stateD  = SEARCH;
          accD    = '0;
          bitIdxD = CNT_W'(WIDTH - 1);
          trialD  = WIDTH'(1) << (WIDTH - 1);
          errD    = 1'b0;
          probesD = '0;
        end
      end
      SEARCH: begin
        probesD = probesQ + CNT_W'(1);
        if (!is_onehot3(bus.cmp_gt, bus.cmp_lt, bus.cmp_eq)) begin
          errD    = 1'b1;
          resultD = '0;
          doneD   = 1'b1;
          stateD  = IDLE;
          trialD  = '0;
        end else if (bus.cmp_eq) begin
          resultD = trialQ;
          doneD   = 1'b1;
          stateD  = IDLE;
          trialD  = '0;
        end else if (bitIdxQ == '0) begin
          resultD = accNext;
          doneD   = 1'b1;
          stateD  = IDLE;
          trialD  = '0;
        end else begin
          bitIdxD = bitIdxQ - CNT_W'(1);
          accD    = accNext;
          trialD  = accNext | (WIDTH'(1) << (bitIdxQ - CNT_W'(1)));
        end
      end
      default: stateD = IDLE;
    endcase
  end

  assign bus.trial    = trialQ;
  assign bus.busy     = (stateQ == SEARCH);
  assign bus.done     = doneQ;
  assign bus.result   = resultQ;
  assign bus.err      = errQ;
  assign bus.probes   = probesQ;
  assign bus.dbgState = stateQ;

endmodule
